timer_dev: RTL

// - Memory-mapped countdown timer. It sits directly downstream of the CPU data port, on the same memaddr/memdata/memwrite bus that feeds DM.
// - Software programs a preset and a control word. The timer counts down once per clock and raises irq on expiry.
// - Read data returns on memout. The top level muxes memout into the register write-back path when memaddr hits this block.

---
 rtl/timer_dev.sv | 100 ++++++++++
 1 files changed

// File: rtl/timer_dev.sv
// Memory-mapped countdown timer on the CPU data bus: CTRL/PRESET/COUNT registers
// in a 16-byte window, one decrement per clock, registered irq on expiry.
module timer_dev #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_7F00
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] memaddr,
  input  logic [31:0] memdata,
  input  logic        memwrite,
  output logic [31:0] memout,
  output logic        irq
);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_CNT, S_INT} state_t;

  state_t      state_q, state_d;
  logic [3:0]  ctrl_q, ctrl_d;
  logic [31:0] preset_q, preset_d;
  logic [31:0] count_q, count_d;
  logic        irq_q, irq_d;

  logic        hit;
  logic [1:0]  off;
  logic        wr_ctrl;
  logic        wr_preset;
  logic        reload_mode;
  logic        unused_addr_bits;

  assign hit              = (memaddr[31:4] == BASE_ADDR[31:4]);
  assign off              = memaddr[3:2];
  assign wr_ctrl          = memwrite & hit & (off == 2'd0);
  assign wr_preset        = memwrite & hit & (off == 2'd1);
  assign reload_mode      = (ctrl_q[2:1] == 2'b01);
  assign unused_addr_bits = ^memaddr[1:0];

  always_comb begin
    memout = 32'h0;
    if (hit) begin
      case (off)
        2'd0:    memout = {28'b0, ctrl_q};
        2'd1:    memout = preset_q;
        2'd2:    memout = count_q;
        default: memout = 32'h0;
      endcase
    end
  end

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    ctrl_d   = wr_ctrl ? memdata[3:0] : ctrl_q;
    preset_d = wr_preset ? memdata : preset_q;
    case (state_q)
      // A same-edge CTRL store enabling the timer starts the load immediately.
      S_IDLE: if (ctrl_d[0]) state_d = S_LOAD;
      S_LOAD: begin
        count_d = preset_q;
        state_d = S_CNT;
      end
      S_CNT: begin
        if (ctrl_q[0]) begin
          if (count_q > 32'd1) begin
            count_d = count_q - 32'd1;
          end else begin
            count_d = 32'h0;
            state_d = S_INT;
            // One-shot expiry disarms EN unless software stores CTRL on this edge.
            if (!reload_mode && !wr_ctrl) ctrl_d[0] = 1'b0;
          end
        end
      end
      S_INT: begin
        if (reload_mode)  state_d = S_LOAD;
        else if (wr_ctrl) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    irq_d = (state_d == S_INT) & ctrl_d[3];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      ctrl_q   <= 4'h0;
      preset_q <= 32'h0;
      count_q  <= 32'h0;
      irq_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      ctrl_q   <= ctrl_d;
      preset_q <= preset_d;
      count_q  <= count_d;
      irq_q    <= irq_d;
    end
  end

  assign irq = irq_q;

endmodule
